// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: round-robin sharing of one SPI flash reader between fetch (port 0) and load (port 1),
// with a one-entry last-word buffer that answers repeat addresses without touching the flash.
module spi_flash_arbiter #(
    parameter int ADDR_W     = 20,
    parameter bit BUF_EN     = 1'b1,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rstrb0,
    input  logic [ADDR_W-1:0] addr0,
    output logic [31:0]       rdata0,
    output logic              rbusy0,
    input  logic              rstrb1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [31:0]       rdata1,
    output logic              rbusy1,
    input  logic              inval,
    output logic              f_rstrb,
    output logic [ADDR_W-1:0] f_addr,
    input  logic [31:0]       f_rdata,
    input  logic              f_rbusy
);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DELIVER} state_t;
    state_t            r_state, w_next;
    logic [1:0]        r_pend;
    logic [ADDR_W-1:0] r_req_addr0, r_req_addr1, r_buf_addr, r_f_addr;
    logic [31:0]       r_buf_data, r_rdata0, r_rdata1;
    logic              r_rr_last, r_grant, r_buf_valid;
    logic [GW-1:0]     r_gap_cnt;
    logic              w_gnt, w_hit, w_capture, w_deliver;
    logic [ADDR_W-1:0] w_gnt_addr;
    // On a tie the port that did not win last time gets the grant.
    assign w_gnt      = (&r_pend) ? ~r_rr_last : r_pend[1];
    assign w_gnt_addr = w_gnt ? r_req_addr1 : r_req_addr0;
    assign w_hit      = BUF_EN && r_buf_valid && (r_buf_addr == w_gnt_addr);
    assign w_capture  = (r_state == WAIT_DONE) && !f_rbusy;
    assign w_deliver  = (r_state == DELIVER);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // The re-arm gap only holds back flash issues; buffer hits proceed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (|r_pend) w_next = w_hit ? DELIVER : ((r_gap_cnt == '0) ? ISSUE : IDLE);
            ISSUE:     if (f_rbusy) w_next = WAIT_DONE;
            WAIT_DONE: if (!f_rbusy) w_next = DELIVER;
            default:   w_next = IDLE;
        endcase
    end
    always_comb begin
        f_rstrb = (r_state == ISSUE);
        rbusy0  = rstrb0 | r_pend[0];
        rbusy1  = rstrb1 | r_pend[1];
    end
    assign f_addr = r_f_addr;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend      <= '0;
            r_req_addr0 <= '0;
            r_req_addr1 <= '0;
            r_rr_last   <= 1'b1;
            r_grant     <= 1'b0;
            r_f_addr    <= '0;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_gap_cnt   <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            if (rstrb0 && !r_pend[0]) begin
                r_pend[0]   <= 1'b1;
                r_req_addr0 <= addr0;
            end else if (w_deliver && !r_grant) r_pend[0] <= 1'b0;
            if (rstrb1 && !r_pend[1]) begin
                r_pend[1]   <= 1'b1;
                r_req_addr1 <= addr1;
            end else if (w_deliver && r_grant) r_pend[1] <= 1'b0;
            if (r_state == IDLE && w_next != IDLE) begin
                r_grant   <= w_gnt;
                r_rr_last <= w_gnt;
            end
            if (r_state == IDLE && w_next == ISSUE) r_f_addr <= w_gnt_addr;
            if (w_capture) begin
                r_buf_data <= f_rdata;
                r_buf_addr <= r_f_addr;
            end
            r_buf_valid <= inval ? 1'b0 : (w_capture ? 1'b1 : r_buf_valid);
            r_gap_cnt   <= w_capture ? GW'(GAP_CYCLES) : ((r_gap_cnt != '0) ? r_gap_cnt - 1'b1 : r_gap_cnt);
            if (w_deliver && !r_grant) r_rdata0 <= r_buf_data;
            if (w_deliver && r_grant)  r_rdata1 <= r_buf_data;
        end
    end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: directed tests for spi_flash_arbiter with a behavioural flash reader per DUT
// (dut uses the buffer, dut_b has BUF_EN=0).
module tb_spi_flash_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        rstrb0, rstrb1, inval, b_rstrb0;
    logic [19:0] addr0, addr1, b_addr0;
    logic [31:0] rdata0, rdata1, b_rdata0, b_rdata1;
    logic        rbusy0, rbusy1, b_rbusy0, b_rbusy1;
    logic        fr_strb [2];
    logic [19:0] fr_addr [2];
    logic [19:0] fr_a [2];
    logic [31:0] fr_data [2];
    logic        fr_busy [2];
    int          fr_cnt [2];
    int          nreads [2];
    logic [19:0] flog [8];
    int          lat = 5;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    spi_flash_arbiter #(.ADDR_W(20), .BUF_EN(1'b1), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .rstrb0(rstrb0), .addr0(addr0), .rdata0(rdata0), .rbusy0(rbusy0),
        .rstrb1(rstrb1), .addr1(addr1), .rdata1(rdata1), .rbusy1(rbusy1),
        .inval(inval),
        .f_rstrb(fr_strb[0]), .f_addr(fr_addr[0]), .f_rdata(fr_data[0]), .f_rbusy(fr_busy[0])
    );

    spi_flash_arbiter #(.ADDR_W(20), .BUF_EN(1'b0), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset),
        .rstrb0(b_rstrb0), .addr0(b_addr0), .rdata0(b_rdata0), .rbusy0(b_rbusy0),
        .rstrb1(1'b0), .addr1(20'h0), .rdata1(b_rdata1), .rbusy1(b_rbusy1),
        .inval(1'b0),
        .f_rstrb(fr_strb[1]), .f_addr(fr_addr[1]), .f_rdata(fr_data[1]), .f_rbusy(fr_busy[1])
    );

    function automatic logic [31:0] fdata(input logic [19:0] a);
        return (a == 20'h00100) ? 32'hDEADBEEF : {12'hC0D, a};
    endfunction

    // Flash reader model: accepts a level strobe, stays busy for lat cycles, then presents data.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                fr_busy[k] <= 1'b0;
                fr_cnt[k]  <= 0;
                fr_data[k] <= '0;
                fr_a[k]    <= '0;
                nreads[k]  <= 0;
            end else if (!fr_busy[k] && fr_strb[k]) begin
                fr_busy[k] <= 1'b1;
                fr_cnt[k]  <= lat;
                fr_a[k]    <= fr_addr[k];
                nreads[k]  <= nreads[k] + 1;
                if (k == 0) flog[nreads[0] % 8] <= fr_addr[0];
            end else if (fr_busy[k]) begin
                fr_cnt[k] <= fr_cnt[k] - 1;
                if (fr_cnt[k] == 1) begin
                    fr_busy[k] <= 1'b0;
                    fr_data[k] <= fdata(fr_a[k]);
                end
            end
        end
    end

    task automatic strobe0(input logic [19:0] a);
        @(posedge clk); #1 rstrb0 = 1'b1; addr0 = a;
        @(posedge clk); #1 rstrb0 = 1'b0;
    endtask

    task automatic strobe1(input logic [19:0] a);
        @(posedge clk); #1 rstrb1 = 1'b1; addr1 = a;
        @(posedge clk); #1 rstrb1 = 1'b0;
    endtask

    task automatic do_reset;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (rbusy0 !== 1'b0) begin errors++; $display("FAIL reset_rbusy0: got %b want 0", rbusy0); end
        checks++; if (rbusy1 !== 1'b0) begin errors++; $display("FAIL reset_rbusy1: got %b want 0", rbusy1); end
        checks++; if (fr_strb[0] !== 1'b0) begin errors++; $display("FAIL reset_f_rstrb: got %b want 0", fr_strb[0]); end
        checks++; if (fr_addr[0] !== 20'h0) begin errors++; $display("FAIL reset_f_addr: got %h want 0", fr_addr[0]); end
        checks++; if ({rdata0, rdata1} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1); end
    endtask

    task automatic test_miss;
        int n;
        lat = 70;
        strobe0(20'h00100);
        n = 0;
        do begin @(negedge clk); n++; end while (!fr_strb[0] && n < 10);
        checks++; if (fr_strb[0] !== 1'b1) begin errors++; $display("FAIL miss_issue: f_rstrb %b want 1", fr_strb[0]); end
        checks++; if (fr_addr[0] !== 20'h00100) begin errors++; $display("FAIL miss_addr: got %h want 00100", fr_addr[0]); end
        n = 0;
        while (!fr_busy[0] && n < 10) begin @(negedge clk); n++; end
        checks++; if (fr_strb[0] !== 1'b1 || fr_busy[0] !== 1'b1) begin errors++; $display("FAIL miss_strobe_held: f_rstrb %b f_rbusy %b want 1 1", fr_strb[0], fr_busy[0]); end
        @(negedge clk);
        checks++; if (fr_strb[0] !== 1'b0) begin errors++; $display("FAIL miss_strobe_drop: got %b want 0", fr_strb[0]); end
        n = 0;
        while (fr_busy[0] && n < 200) begin @(negedge clk); n++; end
        checks++; if (fr_busy[0] !== 1'b0) begin errors++; $display("FAIL miss_flash_timeout: f_rbusy %b want 0", fr_busy[0]); end
        @(negedge clk);
        checks++; if (rbusy0 !== 1'b1) begin errors++; $display("FAIL miss_deliver_busy: got %b want 1", rbusy0); end
        @(negedge clk);
        checks++; if (rbusy0 !== 1'b0) begin errors++; $display("FAIL miss_busy_fall: got %b want 0", rbusy0); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_rdata0: got %h want deadbeef", rdata0); end
        checks++; if (nreads[0] !== 1) begin errors++; $display("FAIL miss_reads: got %0d want 1", nreads[0]); end
    endtask

    task automatic test_hit;
        int n0;
        logic [3:0] seen;
        n0 = nreads[0];
        @(posedge clk); #1 rstrb1 = 1'b1; addr1 = 20'h00100;
        @(negedge clk); seen[3] = rbusy1;
        @(posedge clk); #1 rstrb1 = 1'b0;
        for (int i = 2; i >= 0; i--) begin @(negedge clk); seen[i] = rbusy1; end
        checks++; if (seen !== 4'b1110) begin errors++; $display("FAIL hit_busy_profile: got %b want 1110", seen); end
        checks++; if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_rdata1: got %h want deadbeef", rdata1); end
        checks++; if (nreads[0] !== n0) begin errors++; $display("FAIL hit_no_flash: reads %0d want %0d", nreads[0], n0); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_rdata0_kept: got %h want deadbeef", rdata0); end
    endtask

    task automatic test_inval_gap;
        int n0, cyc, t_fall, t_rise;
        logic prev;
        lat = 10;
        n0 = nreads[0];
        @(posedge clk); #1 inval = 1'b1;
        @(posedge clk); #1 inval = 1'b0;
        strobe0(20'h00100);
        strobe1(20'h00200);
        cyc = 0; t_fall = -1; t_rise = -1; prev = 1'b0;
        while ((rbusy0 || rbusy1) && cyc < 300) begin
            @(negedge clk); cyc++;
            if (prev && !fr_busy[0] && t_fall < 0) t_fall = cyc;
            if (t_fall >= 0 && fr_strb[0] && t_rise < 0) t_rise = cyc;
            prev = fr_busy[0];
        end
        checks++; if (rbusy0 || rbusy1) begin errors++; $display("FAIL inval_timeout: rbusy %b%b want 00", rbusy1, rbusy0); end
        checks++; if (nreads[0] !== n0 + 2) begin errors++; $display("FAIL inval_reads: got %0d want %0d", nreads[0], n0 + 2); end
        checks++; if (t_rise - t_fall !== 4) begin errors++; $display("FAIL gap_cycles: got %0d want 4", t_rise - t_fall); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL inval_rdata0: got %h want deadbeef", rdata0); end
        checks++; if (rdata1 !== 32'hC0D00200) begin errors++; $display("FAIL inval_rdata1: got %h want c0d00200", rdata1); end
    endtask

    task automatic test_tie;
        int n;
        lat = 5;
        do_reset;
        @(posedge clk); #1 rstrb0 = 1'b1; addr0 = 20'h10; rstrb1 = 1'b1; addr1 = 20'h20;
        @(posedge clk); #1 rstrb0 = 1'b0; rstrb1 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (rbusy0 && n < 200);
        checks++; if (rbusy0 !== 1'b0 || rbusy1 !== 1'b1) begin errors++; $display("FAIL tie_first_done: rbusy0 %b rbusy1 %b want 0 1", rbusy0, rbusy1); end
        n = 0;
        while (rbusy1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (flog[0] !== 20'h10 || flog[1] !== 20'h20) begin errors++; $display("FAIL tie_order: got %h,%h want 00010,00020", flog[0], flog[1]); end
        checks++; if (rdata0 !== 32'hC0D00010 || rdata1 !== 32'hC0D00020) begin errors++; $display("FAIL tie_rdata: got %h/%h want c0d00010/c0d00020", rdata0, rdata1); end
        strobe0(20'h30);
        n = 0;
        while (rbusy0 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1 rstrb0 = 1'b1; addr0 = 20'h40; rstrb1 = 1'b1; addr1 = 20'h50;
        @(posedge clk); #1 rstrb0 = 1'b0; rstrb1 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while ((rbusy0 || rbusy1) && n < 300);
        checks++; if (flog[3] !== 20'h50 || flog[4] !== 20'h40) begin errors++; $display("FAIL tie_rr_port1: got %h,%h want 00050,00040", flog[3], flog[4]); end
    endtask

    task automatic test_reset_mid;
        int n;
        lat = 20;
        strobe0(20'h77);
        n = 0;
        do begin @(negedge clk); n++; end while (!(fr_busy[0] && !fr_strb[0]) && n < 50);
        #1 reset = 1'b1;
        #1;
        checks++; if ({rbusy0, rbusy1, fr_strb[0]} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b want 000", {rbusy0, rbusy1, fr_strb[0]}); end
        checks++; if (fr_addr[0] !== 20'h0) begin errors++; $display("FAIL midreset_f_addr: got %h want 0", fr_addr[0]); end
        checks++; if ({rdata0, rdata1} !== 64'h0) begin errors++; $display("FAIL midreset_rdata: got %h/%h want 0/0", rdata0, rdata1); end
        @(posedge clk); #1 reset = 1'b0;
        strobe0(20'h88);
        n = 0;
        while (rbusy0 && n < 200) begin @(negedge clk); n++; end
        checks++; if (rbusy0 !== 1'b0 || rdata0 !== 32'hC0D00088) begin errors++; $display("FAIL midreset_recover: rbusy0 %b rdata0 %h want 0 c0d00088", rbusy0, rdata0); end
    endtask

    task automatic test_no_buf;
        int n, n0;
        logic [31:0] first;
        lat = 5;
        n0 = nreads[1];
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1 b_rstrb0 = 1'b1; b_addr0 = 20'h00100;
            @(posedge clk); #1 b_rstrb0 = 1'b0;
            n = 0;
            while (b_rbusy0 && n < 200) begin @(negedge clk); n++; end
            if (r == 0) first = b_rdata0;
        end
        checks++; if (nreads[1] !== n0 + 2) begin errors++; $display("FAIL nobuf_reads: got %0d want %0d", nreads[1], n0 + 2); end
        checks++; if (first !== 32'hDEADBEEF || b_rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL nobuf_rdata: got %h/%h want deadbeef/deadbeef", first, b_rdata0); end
    endtask

    initial begin
        reset = 1'b0; rstrb0 = 1'b0; rstrb1 = 1'b0; inval = 1'b0; b_rstrb0 = 1'b0;
        addr0 = '0; addr1 = '0; b_addr0 = '0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset;
        test_miss;
        test_hit;
        test_inval_gap;
        test_tie;
        test_reset_mid;
        test_no_buf;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
